// File: rtl/bfp_block_encoder.sv
// Packs 16 bfloat16 elements into one shared exponent plus 4-bit sign-magnitude lanes.
// Latency: o_valid asserts two cycles after the cycle that accepts the 16th element.
// Backpressure: o_ready drops outside COLLECT; the block is held until i_ready. Build option: BFP_ENC_ROUND_EN.
module bfp_block_encoder #(
    parameter int N_LANES  = 16,
    parameter int EXP_W    = 8,
    parameter int IN_MAN_W = 7,
    parameter int MAG_W    = 3
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_valid,
    input  logic [EXP_W+IN_MAN_W:0]                 i_data,
    output logic                                    o_ready,
    output logic                                    o_valid,
    input  logic                                    i_ready,
    output logic [EXP_W-1:0]                        o_E,
    output logic [N_LANES*(MAG_W+1)-1:0]            o_M,
    output logic [N_LANES*(MAG_W+1+EXP_W)-1:0]      o_block
);
    localparam int ELEM_W = 1 + EXP_W + IN_MAN_W;
    localparam int SIG_W  = IN_MAN_W + 1;
    localparam int LANE_W = MAG_W + 1;
    localparam int BLK_W  = 1 + EXP_W + MAG_W;
    localparam int CNT_W  = $clog2(N_LANES);

    typedef enum logic [1:0] {COLLECT, ALIGN, OUT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [EXP_W-1:0]           max_q, max_d;
    logic [ELEM_W-1:0]          lane_q [N_LANES];
    logic [ELEM_W-1:0]          lane_d [N_LANES];
    logic                       valid_q, valid_d;
    logic [EXP_W-1:0]           e_q, e_d;
    logic [N_LANES*LANE_W-1:0]  m_q, m_d;
    logic [N_LANES*BLK_W-1:0]   blk_q, blk_d;

    // Shifts the significand down to the shared exponent; shifts of SIG_W or more leave zero.
    function automatic logic [MAG_W-1:0] align_mag(
        input logic [EXP_W-1:0]    exp,
        input logic [IN_MAN_W-1:0] frac,
        input logic [EXP_W-1:0]    shared_e
    );
        logic [SIG_W-1:0] sig;
        logic [SIG_W-1:0] sh;
        logic [MAG_W-1:0] top;
`ifdef BFP_ENC_ROUND_EN
        logic [MAG_W:0]   rnd;
`endif
        sig = (exp == '0) ? '0 : {1'b1, frac};
        sh  = sig >> (shared_e - exp);
        top = MAG_W'(sh >> (SIG_W - MAG_W));
`ifdef BFP_ENC_ROUND_EN
        rnd = {1'b0, top} + {{MAG_W{1'b0}}, sh[SIG_W-1-MAG_W]};
        return rnd[MAG_W] ? {MAG_W{1'b1}} : rnd[MAG_W-1:0];
`else
        return top;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        e_d     = e_q;
        m_d     = m_q;
        blk_d   = blk_q;
        case (state_q)
            COLLECT: begin
                if (i_valid) begin
                    lane_d[cnt_q] = i_data;
                    if (i_data[ELEM_W-2 -: EXP_W] > max_q)
                        max_d = i_data[ELEM_W-2 -: EXP_W];
                    if (cnt_q == CNT_W'(N_LANES - 1)) begin
                        cnt_d   = '0;
                        state_d = ALIGN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ALIGN: begin
                e_d = max_q;
                for (int i = 0; i < N_LANES; i++) begin
                    m_d[i*LANE_W +: LANE_W] = {lane_q[i][ELEM_W-1],
                        align_mag(lane_q[i][ELEM_W-2 -: EXP_W], lane_q[i][IN_MAN_W-1:0], max_q)};
                    blk_d[i*BLK_W +: BLK_W] = {lane_q[i][ELEM_W-1], max_q,
                        align_mag(lane_q[i][ELEM_W-2 -: EXP_W], lane_q[i][IN_MAN_W-1:0], max_q)};
                end
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    max_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            max_q   <= '0;
            lane_q  <= '{default: '0};
            valid_q <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            e_q     <= e_d;
            m_q     <= m_d;
            blk_q   <= blk_d;
        end
    end

    assign o_ready = (state_q == COLLECT);
    assign o_valid = valid_q;
    assign o_E     = e_q;
    assign o_M     = m_q;
    assign o_block = blk_q;
endmodule

// File: tb/tb_bfp_block_encoder.sv
// Directed bench for bfp_block_encoder: real-arithmetic reference model plus hand-computed pins.
module tb_bfp_block_encoder;
    localparam int N = 16;

    logic         i_clk   = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [15:0]  i_data  = '0;
    logic         o_ready;
    logic         o_valid;
    logic [7:0]   o_E;
    logic [63:0]  o_M;
    logic [191:0] o_block;

    always #5 i_clk = ~i_clk;

    bfp_block_encoder dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_E     (o_E),
        .o_M     (o_M),
        .o_block (o_block)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] blk [N];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Element value is (1+f/128)*2^(e-127); the lane encodes mag/4*2^(E-127), so mag = 4*value*2^(127-E).
    function automatic logic [2:0] model_mag(input logic [15:0] x, input logic [7:0] shared_e);
        real v;
        int  m;
        if (x[14:7] == 8'd0) return 3'd0;
        v = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (real'(x[14:7]) - real'(shared_e)));
`ifdef BFP_ENC_ROUND_EN
        m = int'($floor(v * 4.0 + 0.5));
`else
        m = int'($floor(v * 4.0));
`endif
        if (m > 7) m = 7;
        return 3'(m);
    endfunction

    logic [15:0]  acc [N];
    int           acc_n   = 0;
    logic         m_valid = 1'b0;
    logic         m_align = 1'b0;
    logic [7:0]   m_E     = '0;
    logic [63:0]  m_M     = '0;
    logic [191:0] m_blk   = '0;

    always @(posedge i_clk) begin
        logic [7:0]   e;
        logic [63:0]  mm;
        logic [191:0] bb;
        logic [2:0]   mg;
        if (i_reset) begin
            acc_n   <= 0;
            m_valid <= 1'b0;
            m_align <= 1'b0;
            m_E     <= '0;
            m_M     <= '0;
            m_blk   <= '0;
        end else if (m_valid) begin
            if (i_ready) m_valid <= 1'b0;
        end else if (m_align) begin
            e = 8'd0;
            for (int i = 0; i < N; i++)
                if (acc[i][14:7] > e) e = acc[i][14:7];
            mm = '0;
            bb = '0;
            for (int i = 0; i < N; i++) begin
                mg = model_mag(acc[i], e);
                mm[4*i +: 4]   = {acc[i][15], mg};
                bb[12*i +: 12] = {acc[i][15], e, mg};
            end
            m_E     <= e;
            m_M     <= mm;
            m_blk   <= bb;
            m_valid <= 1'b1;
            m_align <= 1'b0;
            acc_n   <= 0;
        end else if (i_valid) begin
            acc[acc_n] <= i_data;
            acc_n      <= acc_n + 1;
            if (acc_n == N - 1) m_align <= 1'b1;
        end
    end

    always @(negedge i_clk) begin
        chk("o_valid", {191'd0, o_valid}, {191'd0, m_valid});
        chk("o_ready", {191'd0, o_ready}, {191'd0, !m_valid && !m_align});
        chk("o_E", {184'd0, o_E}, {184'd0, m_E});
        chk("o_M", {128'd0, o_M}, {128'd0, m_M});
        chk("o_block", o_block, m_blk);
    end

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < N; i++) blk[i] = v;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = blk[i];
            @(negedge i_clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("drain_valid_low", {191'd0, o_valid}, 192'd0);
        chk("drain_ready_high", {191'd0, o_ready}, 192'd1);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("reset_valid", {191'd0, o_valid}, 192'd0);
        chk("reset_ready", {191'd0, o_ready}, 192'd1);
        chk("reset_block", o_block, 192'd0);
        i_reset = 1'b0;

        // All 1.0
        fill(16'h3F80);
        feed(N);
        chk("lat_align_not_valid", {191'd0, o_valid}, 192'd0);
        @(negedge i_clk);
        chk("lat_valid", {191'd0, o_valid}, 192'd1);
        chk("ones_E", {184'd0, o_E}, 192'd127);
        chk("ones_M", {128'd0, o_M}, {128'd0, {16{4'h4}}});
        chk("ones_lane0", {180'd0, o_block[11:0]}, {180'd0, 12'h3FC});
        drain();

        // 2.0 in lane 0, -1.5 in lane 5, with backpressure
        fill(16'h3F80);
        blk[0] = 16'h4000;
        blk[5] = 16'hBFC0;
        feed(N);
        @(negedge i_clk);
        chk("two_E", {184'd0, o_E}, 192'd128);
        chk("two_lane0", {188'd0, o_M[3:0]}, 192'h4);
        chk("two_lane1", {188'd0, o_M[7:4]}, 192'h2);
        chk("two_lane5", {188'd0, o_M[23:20]}, 192'hB);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk("bp_valid", {191'd0, o_valid}, 192'd1);
            chk("bp_ready", {191'd0, o_ready}, 192'd0);
            chk("bp_E", {184'd0, o_E}, 192'd128);
            chk("bp_lane5", {188'd0, o_M[23:20]}, 192'hB);
        end
        drain();

        // Small values and rounding boundary
        fill(16'h3F80);
        blk[3] = 16'h3E80;
        blk[4] = 16'h3E00;
        blk[6] = 16'h3FF0;
        feed(N);
        @(negedge i_clk);
        chk("small_E", {184'd0, o_E}, 192'd127);
        chk("small_lane3", {188'd0, o_M[15:12]}, 192'h1);
`ifdef BFP_ENC_ROUND_EN
        chk("small_lane4", {188'd0, o_M[19:16]}, 192'h1);
`else
        chk("small_lane4", {188'd0, o_M[19:16]}, 192'h0);
`endif
        chk("small_lane6", {188'd0, o_M[27:24]}, 192'h7);
        drain();

        // Zeros and denormals with sign
        for (int i = 0; i < N; i++) blk[i] = (i % 2 == 1) ? 16'h8001 : 16'h0000;
        feed(N);
        @(negedge i_clk);
        chk("zero_E", {184'd0, o_E}, 192'd0);
        chk("zero_M", {128'd0, o_M}, {128'd0, {8{8'h80}}});
        chk("zero_lane1_blk", {180'd0, o_block[23:12]}, {180'd0, 12'h800});
        drain();

        // Inf exponent treated as ordinary
        fill(16'h3F80);
        blk[2] = 16'h7F80;
        feed(N);
        @(negedge i_clk);
        chk("inf_E", {184'd0, o_E}, 192'd255);
        chk("inf_lane2", {188'd0, o_M[11:8]}, 192'h4);
        chk("inf_lane0", {188'd0, o_M[3:0]}, 192'h0);
        drain();

        // Reset mid-block discards partial data
        fill(16'h4000);
        feed(7);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("midrst_ready", {191'd0, o_ready}, 192'd1);
        fill(16'h3F80);
        feed(N);
        @(negedge i_clk);
        chk("midrst_E", {184'd0, o_E}, 192'd127);
        chk("midrst_M", {128'd0, o_M}, {128'd0, {16{4'h4}}});

        // Reset while a block is pending drops it
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("outrst_valid", {191'd0, o_valid}, 192'd0);
        chk("outrst_E", {184'd0, o_E}, 192'd0);

        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
